iic_cfg_seq: RTL and testbench
==============================

# iic_cfg_seq

Register-configuration sequencer sitting directly upstream of the I2C command master `iic_cm`. After reset it waits a power-up delay, then walks a constant table of register writes, presenting each as a 24-bit word `{DEV_ADDR, reg, data}` on `iic_data` with a level `iic_tr_go` request. It advances only on `iic_tr_done` from `iic_cm`, retries timed-out transfers, and reports overall done or error to the SDR control logic.

## Interface
- `NUM_REGS`, 16: number of table entries (1..256).
- `DEV_ADDR`, 8'h34: 8-bit device write address, the high byte of every word.
- `STARTUP_CYCLES`, 50000: power-up wait in `clk_50m` cycles (1 ms).
- `TIMEOUT_CYCLES`, 100000: maximum wait for `iic_tr_done` per attempt (2 ms).
- `GAP_CYCLES`, 500: minimum `iic_tr_go` low time between transfers.
- `MAX_RETRY`, 2: retries per entry after a timeout.
- `clk_50m`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_start`  in  1  one-cycle pulse; restarts the sequence from entry 0. Honoured only in DONE or ERR.
- `iic_data`  out  24  `{DEV_ADDR, reg[7:0], data[7:0]}` for the current entry.
- `iic_tr_go`  out  1  transfer request to `iic_cm`, level.
- `iic_tr_done`  in  1  one-cycle completion pulse from `iic_cm`.
- `cfg_busy`  out  1  high from leaving reset until DONE or ERR.
- `cfg_done`  out  1  high in DONE: all entries written.
- `cfg_err`  out  1  high in ERR: retries exhausted.
- `cfg_index`  out  8  index of the current or failing entry.

## Operation
- States: WAIT_PWR, LOAD, GO, GAP, DONE, ERR.
- WAIT_PWR: count `STARTUP_CYCLES`, then go to LOAD with index 0 and retry count 0.
- LOAD: one cycle. Register the table entry into `iic_data`, then go to GO.
- GO: `iic_tr_go`=1 and the timeout counter runs. `iic_data` holds stable for the whole request.
  - `iic_tr_done` → drop go and clear retries. At the last index go to DONE; otherwise increment the index and go to GAP.
  - Timeout counter reaches `TIMEOUT_CYCLES-1` without done → drop go. If retries < `MAX_RETRY`, increment retries and go to GAP with the same index; otherwise go to ERR.
- GAP: `iic_tr_go`=0 for exactly `GAP_CYCLES` cycles, then go to LOAD. This guarantees `iic_cm`, which is level-sensitive, sees a deasserted request.
- DONE / ERR: outputs hold. `cfg_start` → LOAD with index 0 and retries 0; the power-up wait is skipped.
- Pulse handling:
  - `iic_tr_done` seen outside GO is ignored.
  - `iic_tr_done` on the same cycle as the timeout expiry counts as success.
  - `cfg_start` outside DONE/ERR is ignored.
- Table: combinational lookup by index, 16 bits `{reg, data}`. Entries at or beyond `NUM_REGS` are never addressed.

## Timing
- Reset values, effective on the first `clk_50m` edge with `rst`=1:
  - state = WAIT_PWR, `iic_tr_go`=0, `iic_data`=0, `cfg_index`=0;
  - `cfg_busy`=1, `cfg_done`=0, `cfg_err`=0;
  - all counters 0.
- Reset mid-transfer drops `iic_tr_go` on the next edge and restarts from WAIT_PWR.
- From `rst` deassertion to the first `iic_tr_go` rise: `STARTUP_CYCLES`+1 cycles.
- `iic_data` is valid one cycle before `iic_tr_go` rises.
- `iic_tr_done` sampled high → `iic_tr_go` low on the next edge.
- From `iic_tr_done` to the next `iic_tr_go` rise: `GAP_CYCLES`+1 cycles.
- `cfg_done`, `cfg_err` and the `cfg_busy` fall are registered and change on the edge that enters DONE or ERR.
- Counter widths: `$clog2` of the larger of `STARTUP_CYCLES`, `TIMEOUT_CYCLES` and `GAP_CYCLES`. A single counter is shared across states and cleared on every state change.

## Structure
- Shared include `iic_cfg_defs.vh` holds:
  - state encodings;
  - table entry width (16);
  - `IIC_WORD_W` = 24, which `iic_cm` uses as well.
- Sub-module `iic_cfg_rom`: index → `{reg, data}` case table, parameterised by `NUM_REGS`, replaceable per target chip.
- The sequencer itself is a single FSM plus the shared counter, the index register and the retry register.

## Test plan
All scenarios use `NUM_REGS`=3, `STARTUP_CYCLES`=10, `TIMEOUT_CYCLES`=200, `GAP_CYCLES`=4, `MAX_RETRY`=2, and table {16'h1E00, 16'h0C00, 16'h0901}.

1. Nominal run: a bench model of `iic_cm` pulses done 50 cycles after go rises.
   - Go first rises 11 cycles after reset release.
   - Words seen, in order: 24'h341E00, 24'h340C00, 24'h340901.
   - `cfg_done`=1 and `cfg_busy`=0 after the third done.
2. Gap check: measure go low time between transfers → exactly 5 cycles from the done pulse to the next go rise.
3. Retry recovery: no done on the first attempt for entry 1, done on the second.
   - Go drops after 200 cycles, and 24'h340C00 is re-sent.
   - The run completes with `cfg_err`=0.
4. Failure: done never arrives for entry 2.
   - Exactly 3 attempts, then `cfg_err`=1 and `cfg_index`=2.
   - `iic_tr_go` stays 0 afterwards.
5. Restart: `cfg_start` pulse in DONE → go rises 2 cycles later with 24'h341E00, with no power-up wait. A `cfg_start` pulse while busy is ignored.
6. Reset mid-transfer: assert `rst` while go is high → go=0 next cycle, all outputs at reset values, and the sequence reruns from entry 0.

Source files
------------

// File: rtl/iic_cfg_seq_pkg.sv
// rtl/iic_cfg_seq_pkg.sv - shared definitions for the I2C register-configuration sequencer
package iic_cfg_seq_pkg;

    // Command word presented to iic_cm: {device address, register, data}
    localparam int IIC_WORD_W = 24;

    // One configuration table entry: {register, data}
    localparam int ENTRY_W = 16;

    typedef enum logic [2:0] {
        ST_WAIT_PWR = 3'd0,
        ST_LOAD     = 3'd1,
        ST_GO       = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } cfg_state_t;

    // Bits needed to hold the values 0 .. n-1, never less than one bit
    function automatic int bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/iic_cfg_seq_rom.sv
// rtl/iic_cfg_seq_rom.sv - index to {reg, data} configuration table, replaceable per target chip
module iic_cfg_rom
    import iic_cfg_seq_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [7:0]         i_index,
    output logic [ENTRY_W-1:0] o_entry
);

    // Nine bits so that a full 256-entry table still compares correctly
    localparam logic [8:0] LIMIT = 9'(NUM_REGS);

    // Combinational table lookup; anything outside the populated range reads as zero
    always_comb begin
        o_entry = '0;
        if ({1'b0, i_index} < LIMIT) begin
            case (i_index)
                8'd0:    o_entry = 16'h1E00;
                8'd1:    o_entry = 16'h0C00;
                8'd2:    o_entry = 16'h0901;
                8'd3:    o_entry = 16'h0017;
                8'd4:    o_entry = 16'h0217;
                8'd5:    o_entry = 16'h0479;
                8'd6:    o_entry = 16'h0679;
                8'd7:    o_entry = 16'h0812;
                8'd8:    o_entry = 16'h0A06;
                8'd9:    o_entry = 16'h0E42;
                8'd10:   o_entry = 16'h1000;
                8'd11:   o_entry = 16'h1200;
                8'd12:   o_entry = 16'h0C02;
                8'd13:   o_entry = 16'h0A00;
                8'd14:   o_entry = 16'h0812;
                8'd15:   o_entry = 16'h1201;
                default: o_entry = '0;
            endcase
        end
    end

endmodule

// File: rtl/iic_cfg_seq.sv
// rtl/iic_cfg_seq.sv - power-up register-configuration sequencer feeding the I2C command master
module iic_cfg_seq
    import iic_cfg_seq_pkg::*;
#(
    parameter int         NUM_REGS       = 16,
    parameter logic [7:0] DEV_ADDR       = 8'h34,
    parameter int         STARTUP_CYCLES = 50000,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         GAP_CYCLES     = 500,
    parameter int         MAX_RETRY      = 2
) (
    input  logic                  i_clk_50m,
    input  logic                  i_rst,
    input  logic                  i_cfg_start,
    output logic [IIC_WORD_W-1:0] o_iic_data,
    output logic                  o_iic_tr_go,
    input  logic                  i_iic_tr_done,
    output logic                  o_cfg_busy,
    output logic                  o_cfg_done,
    output logic                  o_cfg_err,
    output logic [7:0]            o_cfg_index
);

    // One counter serves the power-up wait, the per-attempt timeout and the gap
    localparam int CNT_W = bits_for(max3(STARTUP_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES));
    localparam int RTY_W = bits_for(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       LAST_IDX     = 8'(NUM_REGS - 1);
    localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRY);

    cfg_state_t             r_state;
    cfg_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [7:0]             r_index;
    logic [7:0]             w_index_nxt;
    logic [RTY_W-1:0]       r_retry;
    logic [RTY_W-1:0]       w_retry_nxt;
    logic [ENTRY_W-1:0]     w_entry;
    logic [IIC_WORD_W-1:0]  r_data;
    logic                   r_go;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    // The table is addressed with the index the FSM is about to hold, so the
    // word is registered on the edge that enters LOAD and is stable a full
    // cycle before the request rises.
    iic_cfg_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .i_index  (w_index_nxt),
        .o_entry  (w_entry)
    );

    // Next-state, index, retry and shared-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_retry_nxt = r_retry;
        w_cnt_nxt   = '0;

        unique case (r_state)
            ST_WAIT_PWR: begin
                if (r_cnt == STARTUP_LAST) begin
                    w_state_nxt = ST_LOAD;
                    w_index_nxt = '0;
                    w_retry_nxt = '0;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_GO;
            end
            ST_GO: begin
                // A completion on the expiry cycle still counts as success
                if (i_iic_tr_done) begin
                    w_retry_nxt = '0;
                    if (r_index == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_index_nxt = r_index + 8'd1;
                        w_state_nxt = ST_GAP;
                    end
                end else if (r_cnt == TIMEOUT_LAST) begin
                    if (r_retry < RTY_MAX) begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_DONE, ST_ERR: begin
                if (i_cfg_start) begin
                    w_state_nxt = ST_LOAD;
                    w_index_nxt = '0;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_PWR;
            end
        endcase

        // Counter restarts on every state change and rests in the terminal states
        if ((w_state_nxt != r_state) || (r_state == ST_DONE) || (r_state == ST_ERR)) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // State, counter, index and retry registers
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_state <= ST_WAIT_PWR;
            r_cnt   <= '0;
            r_index <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_index <= w_index_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Registered outputs, decoded from the state being entered so they change on the entering edge
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_data <= '0;
            r_go   <= 1'b0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_state_nxt == ST_LOAD) begin
                r_data <= {DEV_ADDR, w_entry};
            end
            r_go   <= (w_state_nxt == ST_GO);
            r_busy <= !((w_state_nxt == ST_DONE) || (w_state_nxt == ST_ERR));
            r_done <= (w_state_nxt == ST_DONE);
            r_err  <= (w_state_nxt == ST_ERR);
        end
    end

    assign o_iic_data  = r_data;
    assign o_iic_tr_go = r_go;
    assign o_cfg_busy  = r_busy;
    assign o_cfg_done  = r_done;
    assign o_cfg_err   = r_err;
    assign o_cfg_index = r_index;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// tb/tb_iic_cfg_seq.sv - self-checking bench for iic_cfg_seq with an iic_cm responder model
module tb_iic_cfg_seq;

    localparam int STARTUP  = 10;
    localparam int TIMEOUT  = 200;
    localparam int GAP      = 4;
    localparam int DONE_DLY = 50;

    localparam logic [23:0] W0    = 24'h341E00;
    localparam logic [23:0] W1    = 24'h340C00;
    localparam logic [23:0] W2    = 24'h340901;
    localparam logic [23:0] W_BAD = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        iic_tr_done = 1'b0;
    logic [23:0] iic_data;
    logic        iic_tr_go;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [7:0]  cfg_index;

    int cyc = 0;

    int n_cmp = 0;
    int n_mis = 0;

    logic [23:0] exp_q[$];

    logic        prev_go = 1'b0;
    logic [23:0] prev_data = '0;
    logic [23:0] rise_data = '0;
    logic        armed = 1'b0;
    logic        withhold = 1'b0;
    int          wait_cnt = 0;
    int          n_rise = 0;
    int          n_moved = 0;
    int          last_rise_cyc = 0;
    int          last_done_edge = -1;
    int          miss_taken = 0;
    logic [23:0] miss_word = '0;
    int          miss_budget = 0;
    logic        gap_en = 1'b0;
    int          rel_cyc = 0;

    iic_cfg_seq #(
        .NUM_REGS       (3),
        .DEV_ADDR       (8'h34),
        .STARTUP_CYCLES (STARTUP),
        .TIMEOUT_CYCLES (TIMEOUT),
        .GAP_CYCLES     (GAP),
        .MAX_RETRY      (2)
    ) dut (
        .i_clk_50m     (clk),
        .i_rst         (rst),
        .i_cfg_start   (cfg_start),
        .o_iic_data    (iic_data),
        .o_iic_tr_go   (iic_tr_go),
        .i_iic_tr_done (iic_tr_done),
        .o_cfg_busy    (cfg_busy),
        .o_cfg_done    (cfg_done),
        .o_cfg_err     (cfg_err),
        .o_cfg_index   (cfg_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // iic_cm responder and scoreboard, evaluated once per cycle just after the falling edge
    task automatic model_step();
        logic [23:0] exp_w;
        iic_tr_done = 1'b0;
        if (iic_tr_go === 1'b1 && prev_go == 1'b0) begin
            n_rise++;
            last_rise_cyc = cyc;
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : W_BAD;
            check_eq("word", {8'h0, iic_data}, {8'h0, exp_w});
            check_eq("word_pre_go", {8'h0, prev_data}, {8'h0, exp_w});
            if (gap_en && last_done_edge >= 0)
                check_eq("gap", cyc - last_done_edge, GAP + 1);
            last_done_edge = -1;
            withhold = (iic_data == miss_word) && (miss_taken < miss_budget);
            if (withhold) miss_taken++;
            armed = !withhold;
            wait_cnt = 0;
            rise_data = iic_data;
        end else if (iic_tr_go === 1'b1) begin
            wait_cnt++;
            if (iic_data != rise_data) n_moved++;
            if (armed && wait_cnt == DONE_DLY - 1) begin
                iic_tr_done = 1'b1;
                armed = 1'b0;
                last_done_edge = cyc + 1;
            end
        end
        if (iic_tr_go === 1'b0 && prev_go == 1'b1) begin
            if (withhold) check_eq("timeout_len", cyc - last_rise_cyc, TIMEOUT);
            else if (last_done_edge >= 0) check_eq("go_drop", cyc, last_done_edge);
        end
        if (rst) begin
            miss_taken = 0;
            last_done_edge = -1;
        end
        prev_go = (iic_tr_go === 1'b1);
        prev_data = iic_data;
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
    endtask

    task automatic wait_rise(input string tag, input int budget);
        int n0;
        n0 = n_rise;
        for (int i = 0; i < budget && n_rise == n0; i++) step();
        check_eq(tag, n_rise - n0, 1);
    endtask

    task automatic wait_end(input string tag, input int budget);
        for (int i = 0; i < budget && !(cfg_done || cfg_err); i++) step();
        check_eq(tag, {31'b0, cfg_done | cfg_err}, 1);
    endtask

    task automatic check_reset_vals();
        check_eq("rst_go", {31'b0, iic_tr_go}, 0);
        check_eq("rst_data", {8'h0, iic_data}, 0);
        check_eq("rst_index", {24'h0, cfg_index}, 0);
        check_eq("rst_busy", {31'b0, cfg_busy}, 1);
        check_eq("rst_done", {31'b0, cfg_done}, 0);
        check_eq("rst_err", {31'b0, cfg_err}, 0);
    endtask

    task automatic push_run();
        exp_q.push_back(W0);
        exp_q.push_back(W1);
        exp_q.push_back(W2);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        step();
    endtask

    task automatic release_and_first_rise(input string tag);
        rst = 1'b0;
        rel_cyc = cyc;
        wait_rise({tag, "_first_go"}, 40);
        check_eq({tag, "_first_go_lat"}, last_rise_cyc - rel_cyc, STARTUP + 1);
    endtask

    task automatic check_done_state(input string tag, input int rises);
        check_eq({tag, "_done"}, {31'b0, cfg_done}, 1);
        check_eq({tag, "_err"}, {31'b0, cfg_err}, 0);
        check_eq({tag, "_busy"}, {31'b0, cfg_busy}, 0);
        check_eq({tag, "_index"}, {24'h0, cfg_index}, 2);
        check_eq({tag, "_rises"}, n_rise, rises);
        check_eq({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        int c0;

        // Reset state
        step();
        step();
        check_reset_vals();

        // Nominal run with gap measurement
        gap_en = 1'b1;
        push_run();
        n0 = n_rise;
        release_and_first_rise("nom");
        wait_end("nom_end", 2000);
        check_done_state("nom", n0 + 3);
        check_eq("nom_data_stable", n_moved, 0);

        // Restart from DONE, plus an ignored start while busy
        gap_en = 1'b0;
        push_run();
        n0 = n_rise;
        cfg_start = 1'b1;
        c0 = cyc;
        step();
        cfg_start = 1'b0;
        wait_rise("rs_go", 10);
        check_eq("rs_go_lat", last_rise_cyc - c0, 2);
        check_eq("rs_busy", {31'b0, cfg_busy}, 1);
        check_eq("rs_done_clr", {31'b0, cfg_done}, 0);
        repeat (10) step();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        wait_end("rs_end", 2000);
        check_done_state("rs", n0 + 3);

        // Retry recovery: entry 1 misses its first attempt
        gap_en = 1'b1;
        miss_word = W1;
        miss_budget = 1;
        reset_pulse();
        check_reset_vals();
        exp_q.push_back(W0);
        exp_q.push_back(W1);
        exp_q.push_back(W1);
        exp_q.push_back(W2);
        n0 = n_rise;
        release_and_first_rise("rty");
        wait_end("rty_end", 3000);
        check_done_state("rty", n0 + 4);

        // Failure: entry 2 never completes
        miss_word = W2;
        miss_budget = 100;
        reset_pulse();
        exp_q.push_back(W0);
        exp_q.push_back(W1);
        repeat (3) exp_q.push_back(W2);
        n0 = n_rise;
        release_and_first_rise("err");
        wait_end("err_end", 3000);
        check_eq("err_err", {31'b0, cfg_err}, 1);
        check_eq("err_done", {31'b0, cfg_done}, 0);
        check_eq("err_busy", {31'b0, cfg_busy}, 0);
        check_eq("err_index", {24'h0, cfg_index}, 2);
        check_eq("err_attempts", n_rise - n0, 5);
        check_eq("err_q_empty", exp_q.size(), 0);
        c0 = n_rise;
        repeat (300) step();
        check_eq("err_go_quiet", n_rise - c0, 0);
        check_eq("err_go_low", {31'b0, iic_tr_go}, 0);

        // Reset mid-transfer, with a start pulse during power-up that must be ignored
        miss_budget = 0;
        reset_pulse();
        exp_q.push_back(W0);
        rst = 1'b0;
        rel_cyc = cyc;
        repeat (3) step();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        wait_rise("mid_first_go", 40);
        check_eq("mid_first_go_lat", last_rise_cyc - rel_cyc, STARTUP + 1);
        repeat (20) step();
        check_eq("mid_go_high", {31'b0, iic_tr_go}, 1);
        rst = 1'b1;
        step();
        check_reset_vals();
        step();
        push_run();
        n0 = n_rise;
        release_and_first_rise("mid");
        wait_end("mid_end", 2000);
        check_done_state("mid", n0 + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
